mem_port_arbiter: RTL and testbench

- Parametrised successor to the two-client cache/memory front end: arbitrates N_CH requesters (fetcher, LSB, future clients) onto the single byte-wide RAM/IO bus.
- Each accepted request is a 1/2/4-byte read or write, serialised little-endian one byte per cycle.
- Handles IO-buffer back-pressure, rdy_in pause, and RoB flush abort of speculative reads.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates N_CH requesters onto a byte-wide RAM/IO bus, serialising 1/2/4-byte accesses little-endian.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (highest index wins) instead of round-robin.
module mem_port_arbiter #(
    parameter int              N_CH       = 2,
    parameter logic [N_CH-1:0] FLUSH_MASK = {N_CH{1'b1}}
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic [N_CH-1:0]      ch_valid,
    input  logic [N_CH-1:0]      ch_we,
    input  logic [2*N_CH-1:0]    ch_size,
    input  logic [32*N_CH-1:0]   ch_addr,
    input  logic [32*N_CH-1:0]   ch_wdata,
    output logic [N_CH-1:0]      ch_grant,
    output logic [N_CH-1:0]      ch_done,
    output logic [31:0]          rdata,
    output logic                 busy,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr,
    input  logic                 io_buffer_full
);

    // state   | meaning
    // S_IDLE  | arbitrating, bus idle
    // S_READ  | issuing read addresses, then collecting the trailing byte
    // S_WRITE | driving one write byte per cycle, stalls on full IO buffer
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     ch_q, ch_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        nb_q, nb_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [N_CH-1:0]   done_q, done_d;

    logic [N_CH-1:0]   req;
    logic              win_found;
    logic [PW-1:0]     win;
    logic [1:0]        byte_sel;
    logic              io_stall;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Masked channels sit out arbitration during a flush cycle.
    always_comb begin
        req       = ch_valid & ~(flush_in ? FLUSH_MASK : '0);
        win_found = |req;
        win       = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_CH; i++) begin
            if (req[i]) win = PW'(i);
        end
`else
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[(int'(ptr_q) + i) % N_CH]) win = PW'((int'(ptr_q) + i) % N_CH);
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            nb_q    <= '0;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            nb_q    <= nb_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign byte_sel = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        nb_d    = nb_q;
        cnt_d   = cnt_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        grant_d = grant_q;
        done_d  = done_q;
        if (rdy_in) begin
            grant_d = '0;
            done_d  = '0;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        ch_d    = win;
                        addr_d  = ch_addr[32*int'(win) +: 32];
                        wdata_d = ch_wdata[32*int'(win) +: 32];
                        nb_d    = size_bytes(ch_size[2*int'(win) +: 2]);
                        cnt_d   = '0;
                        rbuf_d  = '0;
                        grant_d = N_CH'(1) << win;
                        state_d = ch_we[win] ? S_WRITE : S_READ;
                        ptr_d   = (int'(win) == N_CH - 1) ? '0 : win + 1'b1;
                    end
                end
                S_READ: begin
                    if (flush_in && FLUSH_MASK[ch_q]) begin
                        state_d = S_IDLE;
                    end else begin
                        // mem_din lags the address by one cycle, so cnt_q=k delivers byte k-1.
                        if (cnt_q != 3'd0) rbuf_d[8*byte_sel +: 8] = mem_din;
                        if (cnt_q == nb_q) begin
                            state_d = S_IDLE;
                            done_d  = N_CH'(1) << ch_q;
                            rdata_d = rbuf_d;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (!io_stall) begin
                        if (cnt_q == nb_q - 3'd1) begin
                            state_d = S_IDLE;
                            done_d  = N_CH'(1) << ch_q;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        case (state_q)
            S_READ: begin
                if (cnt_q < nb_q) mem_a = addr_q + 32'(cnt_q);
            end
            S_WRITE: begin
                mem_a    = addr_q + 32'(cnt_q);
                mem_dout = wdata_q[8*cnt_q[1:0] +: 8];
            end
            default: ;
        endcase
    end

    // Bytes aimed at the UART window wait while its TX buffer is full.
    assign io_stall = (state_q == S_WRITE) && (mem_a[17:16] == 2'b11) && io_buffer_full;
    assign mem_wr   = (state_q == S_WRITE) && rdy_in && !io_stall;
    assign busy     = (state_q != S_IDLE);
    assign ch_grant = rdy_in ? grant_q : '0;
    assign ch_done  = rdy_in ? done_q : '0;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal scenarios plus random traffic checked every cycle
// against a transaction-level model; the memory model pauses with rdy_in like the rest of the chip.
module tb_mem_port_arbiter;
    localparam int N = 2;
    localparam logic [N-1:0] FMASK = 2'b11;

    logic            clk_in = 1'b0;
    logic            rst_n_in = 1'b0;
    logic            rdy_in = 1'b1;
    logic            flush_in = 1'b0;
    logic            io_buffer_full = 1'b0;
    logic [N-1:0]    ch_valid = '0;
    logic [N-1:0]    ch_we = '0;
    logic [2*N-1:0]  ch_size = '0;
    logic [32*N-1:0] ch_addr = '0;
    logic [32*N-1:0] ch_wdata = '0;
    logic [N-1:0]    ch_grant, ch_done;
    logic [31:0]     rdata, mem_a;
    logic            busy, mem_wr;
    logic [7:0]      mem_dout;
    logic [7:0]      mem_din = 8'h00;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.N_CH(N), .FLUSH_MASK(FMASK)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .ch_valid(ch_valid), .ch_we(ch_we), .ch_size(ch_size), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_grant(ch_grant), .ch_done(ch_done), .rdata(rdata),
        .busy(busy), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] ram_pre [logic [31:0]];

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (ram_pre.exists(a)) return ram_pre[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    always @(posedge clk_in) if (rdy_in) mem_din <= ram_byte(mem_a);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bytes_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // Transaction-level reference model
    bit          m_active, m_we;
    int          m_ch, m_n, m_pos, m_ptr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [N-1:0] m_gnt, m_done;

    always @(negedge clk_in) begin : model
        logic [31:0] e_a;
        logic [7:0]  e_dout;
        logic        stall, e_wr;
        logic [N-1:0] elig;
        int          w;
        if (!rst_n_in) begin
            m_active = 0; m_we = 0; m_ch = 0; m_n = 0; m_pos = 0; m_ptr = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0; m_gnt = 0; m_done = 0;
        end
        e_a = 0;
        e_dout = 0;
        if (m_active) begin
            if (m_we) begin
                e_a = m_addr + 32'(m_pos);
                e_dout = m_wdata[8*m_pos +: 8];
            end else if (m_pos < m_n) begin
                e_a = m_addr + 32'(m_pos);
            end
        end
        stall = m_active && m_we && (e_a[17:16] == 2'b11) && io_buffer_full;
        e_wr  = m_active && m_we && rdy_in && !stall;
        chk("grant", 32'(ch_grant), rdy_in ? 32'(m_gnt) : 32'd0);
        chk("done", 32'(ch_done), rdy_in ? 32'(m_done) : 32'd0);
        if (m_done != 0) chk("rdata", rdata, m_rdata);
        chk("busy", 32'(busy), 32'(m_active));
        chk("mem_a", mem_a, e_a);
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        chk("mem_dout", 32'(mem_dout), 32'(e_dout));
        if (rst_n_in && rdy_in) begin
            m_gnt = 0;
            m_done = 0;
            if (!m_active) begin
                elig = ch_valid & ~(flush_in ? FMASK : '0);
                w = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
                for (int i = 0; i < N; i++) if (elig[i]) w = i;
`else
                for (int i = 0; i < N; i++) if (w < 0 && elig[(m_ptr + i) % N]) w = (m_ptr + i) % N;
`endif
                if (w >= 0) begin
                    m_active = 1;
                    m_ch = w;
                    m_we = ch_we[w];
                    m_n = bytes_of(ch_size[2*w +: 2]);
                    m_addr = ch_addr[32*w +: 32];
                    m_wdata = ch_wdata[32*w +: 32];
                    m_pos = 0;
                    m_gnt[w] = 1'b1;
                    m_ptr = (w + 1) % N;
                end
            end else if (!m_we) begin
                if (flush_in && FMASK[m_ch]) begin
                    m_active = 0;
                end else if (m_pos == m_n) begin
                    m_active = 0;
                    m_done[m_ch] = 1'b1;
                    m_rdata = 0;
                    for (int k = 0; k < m_n; k++)
                        m_rdata = m_rdata | (32'(ram_byte(m_addr + 32'(k))) << (8*k));
                end else begin
                    m_pos++;
                end
            end else if (!stall) begin
                if (m_pos == m_n - 1) begin
                    m_active = 0;
                    m_done[m_ch] = 1'b1;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    int gcnt[N];
    always @(negedge clk_in) for (int i = 0; i < N; i++) if (ch_grant[i]) gcnt[i]++;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic req(input int c, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        ch_we[c] = we;
        ch_size[2*c +: 2] = sz;
        ch_addr[32*c +: 32] = a;
        ch_wdata[32*c +: 32] = d;
        ch_valid[c] = 1'b1;
    endtask

    task automatic rand_req(input int c);
        ch_we[c] = 1'($urandom);
        ch_size[2*c +: 2] = 2'($urandom);
        case ($urandom % 4)
            0:       ch_addr[32*c +: 32] = {14'($urandom), 2'b11, 16'($urandom)};
            1:       ch_addr[32*c +: 32] = 32'hFFFF_FFFC + 32'($urandom % 4);
            default: ch_addr[32*c +: 32] = $urandom;
        endcase
        ch_wdata[32*c +: 32] = $urandom;
        ch_valid[c] = 1'b1;
    endtask

    int glist[$];
    int gseen[N];
    int exp_g;

    initial begin
        ram_pre[32'h100] = 8'h13; ram_pre[32'h101] = 8'h05;
        ram_pre[32'h102] = 8'h00; ram_pre[32'h103] = 8'h00;
        ram_pre[32'h200] = 8'h34; ram_pre[32'h201] = 8'h12;

        // Reset values
        tick(); tick(); tick();
        chk("rst_grant", 32'(ch_grant), 0); chk("rst_done", 32'(ch_done), 0);
        chk("rst_rdata", rdata, 0); chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_a", mem_a, 0); chk("rst_mem_wr", 32'(mem_wr), 0);
        rst_n_in = 1'b1;

        // Word read at 0x100
        tick(); req(0, 1'b0, 2'd2, 32'h100, 0); #1;
        tick(); ch_valid = '0; #1;
        chk("A_grant", 32'(ch_grant), 1); chk("A_a0", mem_a, 32'h100); chk("A_busy", 32'(busy), 1);
        for (int k = 1; k < 4; k++) begin
            tick(); #1; chk("A_ak", mem_a, 32'h100 + 32'(k));
        end
        tick(); #1; chk("A_a_idle", mem_a, 0); chk("A_early_done", 32'(ch_done), 0);
        tick(); #1; chk("A_done", 32'(ch_done), 1); chk("A_rdata", rdata, 32'h0000_0513);
        chk("A_busy_end", 32'(busy), 0);

        // Both channels held from reset
        rst_n_in = 1'b0; tick(); tick(); rst_n_in = 1'b1;
        tick(); req(0, 1'b0, 2'd0, 32'h10, 0); req(1, 1'b0, 2'd0, 32'h20, 0); #1;
        for (int c = 0; c < 15; c++) begin
            tick(); #1;
            if (ch_grant[0]) glist.push_back(0);
            if (ch_grant[1]) glist.push_back(1);
        end
        ch_valid = '0;
        chk("B_count", 32'(glist.size() >= 4), 1);
        for (int i = 0; i < 4 && i < glist.size(); i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_g = 1;
`else
            exp_g = i % 2;
`endif
            chk("B_order", 32'(glist[i]), 32'(exp_g));
        end
        repeat (4) tick();

        // IO stall on byte write to the UART window
        tick(); req(1, 1'b1, 2'd0, 32'h0003_0000, 32'h41); io_buffer_full = 1'b1; #1;
        tick(); ch_valid = '0; #1;
        chk("C_grant", 32'(ch_grant), 2); chk("C_wr0", 32'(mem_wr), 0); chk("C_a", mem_a, 32'h3_0000);
        tick(); #1; chk("C_wr1", 32'(mem_wr), 0);
        tick(); #1; chk("C_wr2", 32'(mem_wr), 0);
        tick(); io_buffer_full = 1'b0; #1;
        chk("C_wr3", 32'(mem_wr), 1); chk("C_dout", 32'(mem_dout), 32'h41); chk("C_done_early", 32'(ch_done), 0);
        tick(); #1; chk("C_done", 32'(ch_done), 2); chk("C_wr_end", 32'(mem_wr), 0);

        // Flush aborts a read but not a write
        tick(); req(0, 1'b0, 2'd2, 32'h100, 0); #1;
        tick(); ch_valid = '0; #1; chk("D_grant", 32'(ch_grant), 1);
        tick(); #1;
        tick(); flush_in = 1'b1; #1; chk("D_a2", mem_a, 32'h102);
        tick(); flush_in = 1'b0; #1; chk("D_a_abort", mem_a, 0); chk("D_busy", 32'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            tick(); #1; chk("D_no_done", 32'(ch_done), 0);
        end
        tick(); req(1, 1'b1, 2'd1, 32'h500, 32'h0000_BEEF); #1;
        tick(); ch_valid = '0; #1; chk("D_wgrant", 32'(ch_grant), 2);
        tick(); flush_in = 1'b1; #1;
        chk("D_wr", 32'(mem_wr), 1); chk("D_wa", mem_a, 32'h501); chk("D_wdout", 32'(mem_dout), 32'hBE);
        tick(); flush_in = 1'b0; #1; chk("D_wdone", 32'(ch_done), 2);

        // rdy_in low for two cycles mid half-read
        tick(); req(0, 1'b0, 2'd1, 32'h200, 0); #1;
        tick(); ch_valid = '0; #1; chk("E_grant", 32'(ch_grant), 1); chk("E_a0", mem_a, 32'h200);
        tick(); rdy_in = 1'b0; #1; chk("E_a1", mem_a, 32'h201); chk("E_wr", 32'(mem_wr), 0);
        tick(); #1; chk("E_a1_hold", mem_a, 32'h201);
        tick(); rdy_in = 1'b1; #1; chk("E_a1_resume", mem_a, 32'h201); chk("E_done_early", 32'(ch_done), 0);
        tick(); #1; chk("E_a_idle", mem_a, 0); chk("E_done_early2", 32'(ch_done), 0);
        tick(); #1; chk("E_done", 32'(ch_done), 1); chk("E_rdata", rdata, 32'h0000_1234);

        // Reset in the middle of a write
        tick(); req(0, 1'b1, 2'd2, 32'h40, 32'hAABB_CCDD); #1;
        tick(); ch_valid = '0; #1;
        tick(); rst_n_in = 1'b0; #1;
        chk("F_wr", 32'(mem_wr), 0); chk("F_a", mem_a, 0); chk("F_dout", 32'(mem_dout), 0);
        chk("F_busy", 32'(busy), 0); chk("F_rdata", rdata, 0); chk("F_grant", 32'(ch_grant), 0);
        tick(); tick(); rst_n_in = 1'b1;
        tick(); req(0, 1'b0, 2'd0, 32'h10, 0); req(1, 1'b0, 2'd0, 32'h20, 0); #1;
        tick(); ch_valid = '0; #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        chk("F_first_grant", 32'(ch_grant), 2);
`else
        chk("F_first_grant", 32'(ch_grant), 1);
`endif
        repeat (5) tick();

        // Random traffic
        for (int i = 0; i < N; i++) gseen[i] = gcnt[i];
        for (int c = 0; c < 4000; c++) begin
            tick();
            rdy_in = ($urandom % 10) != 0;
            flush_in = ($urandom % 25) == 0;
            io_buffer_full = ($urandom % 5) < 2;
            for (int i = 0; i < N; i++) begin
                if (gcnt[i] != gseen[i]) begin
                    gseen[i] = gcnt[i];
                    ch_valid[i] = 1'b0;
                end else if (ch_valid[i] && ($urandom % 40) == 0) begin
                    ch_valid[i] = 1'b0;
                end else if (!ch_valid[i] && ($urandom % 4) == 0) begin
                    rand_req(i);
                end
            end
        end
        tick();
        rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0; ch_valid = '0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
